genc_core: RTL and testbench
============================

Name: genc_core

Overview:
- Single-cycle 32-bit RV32I-subset processor core.
- Fetches nothing itself: it drives `pc`, and the environment returns the instruction word on `komut` combinationally (word-addressed memory indexed by pc>>2).
- Executes one instruction per clock with an internal 32x32 register file, and flags illegal instructions on `hata`.
- No data-memory interface; it is the top compute block of the test system.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded on reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- komut  input  32  instruction word at current pc, valid combinationally in the same cycle.
- pc  output  32  current program counter, registered.
- hata  output  1  sticky illegal-instruction/fault flag, registered.

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, hata=0.
  - All 32 registers cleared to 0.
- Each rising edge, when not halted:
  - decode komut, read rs1/rs2, compute the result.
  - write rd unless rd=0.
  - update pc.
  - Latency: one cycle per instruction; writeback and pc update on the same edge.
- x0 always reads 0; writes to x0 are discarded.
- Supported instructions, RV32I encodings:
  - LUI, AUIPC.
  - JAL, JALR: rd=pc+4; JALR target=(rs1+imm)&~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: target=pc+B-imm when taken, else pc+4.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Arithmetic rules:
  - 32-bit wrap-around, no overflow traps.
  - Immediates sign-extended.
  - Shift amount = low 5 bits.
  - SLT/BLT signed; SLTU/BLTU unsigned.
- Illegal conditions:
  - Unknown opcode (including LOAD, STORE, FENCE, SYSTEM).
  - Undefined funct3/funct7 combination.
  - Shift-immediate with bad funct7.
  - Taken jump/branch target with target[1:0]!=0.
- On an illegal condition at an edge:
  - hata<=1.
  - No register write; pc holds its value.
- Halted state (hata=1):
  - pc frozen, no register writes, hata stays 1 regardless of komut.
  - Only reset clears it.
- Reset mid-operation: immediate return to reset values, no partial writeback.
- pc increments by 4 with wrap-around at 2^32.

Decomposition:
- Package genc_pkg holds:
  - opcode constants: OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH.
  - funct3/funct7 constants.
  - ALU operation enum.
- Sub-module genc_regfile: 32x32 register file, 2 async read ports, 1 sync write port, async reset, x0 hardwired.
  - Instance name `regfile`, storage array `regs`, so the verification bench can probe register values hierarchically.
- Decoder/immediate generation, ALU and branch compare stay in the core.

Test Plan:
- Reset: hold reset=1 -> pc=0, hata=0, all regs 0; release -> first edge executes komut at pc 0.
- ADDI/SUB: 0x00500093 (addi x1,x0,5), then addi x2,x0,7, then sub x3,x1,x2 -> x1=5, x2=7, x3=0xFFFFFFFE, pc=0x0C.
- Branch: at pc 8, 0x00000463 (beq x0,x0,+8) -> pc=0x10; bne x0,x0,+8 -> pc=pc+4, no register change.
- Jump: at pc 0x20, 0x00C000EF (jal x1,+12) -> x1=0x24, pc=0x2C; jalr x0,0(x1) -> pc=0x24.
- x0 write and illegal opcode:
  - addi x0,x0,1 -> x0 stays 0.
  - komut=0xFFFFFFFF -> after the edge hata=1 and pc frozen for all following cycles.
  - reset -> hata=0, pc=0.
- Fibonacci loop program (addi/add/bne) iterating 20 times -> final register holds 6765 (0x1A6D), hata stays 0, pc ends on the terminal self-loop.

Source files
------------

// File: rtl/genc_pkg.sv
// genc_pkg: shared encodings for the genc single-cycle RV32I-subset core.
// Holds the opcode, funct3 and funct7 constants, the ALU operation enum and
// the writeback source select used by the decoder.
package genc_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 for JALR (only one legal value)
    localparam logic [2:0] F3_JALR = 3'b000;

    // funct7 variants: base ops and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operations
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // Register writeback source
    typedef enum logic [1:0] {
        WB_ALU,
        WB_LUI,
        WB_AUIPC,
        WB_PC4
    } wb_sel_e;

endpackage

// File: rtl/genc_regfile.sv
// genc_regfile: 32x32 register file with two asynchronous read ports and
// one synchronous write port. x0 reads as zero and ignores writes.
module genc_regfile
    import genc_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_we,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data
);

    logic [31:0] regs [32];

    // Clear every register on reset; otherwise write rd when enabled and rd != x0
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (i_we && (i_wr_addr != 5'd0)) begin
            regs[i_wr_addr] <= i_wr_data;
        end
    end

    // x0 is forced to zero at the read ports so it never depends on storage
    assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'd0 : regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'd0 : regs[i_rs2_addr];

endmodule

// File: rtl/genc_core.sv
// genc_core: single-cycle RV32I-subset core. Drives pc, receives the
// instruction on komut in the same cycle, executes it and retires on the
// next rising edge. Any illegal instruction or misaligned taken target
// moves the core into a sticky halted state signalled on hata.
module genc_core
    import genc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] komut,
    output logic [31:0] pc,
    output logic        hata
);

    // Run/halt state; hata is the externally visible view of it
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;

    // Sign-extended immediates
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;

    // Decoder outputs
    alu_op_e     w_alu_op;
    wb_sel_e     w_wb_sel;
    logic        w_use_imm;
    logic        w_wb_en;
    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_dec_illegal;

    // Datapath
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_wr_data;
    logic        w_br_taken;
    logic        w_take;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_misalign;
    logic        w_fault;
    logic        w_running;
    logic        w_rf_we;

    assign w_opcode = komut[6:0];
    assign w_rd     = komut[11:7];
    assign w_funct3 = komut[14:12];
    assign w_rs1    = komut[19:15];
    assign w_rs2    = komut[24:20];
    assign w_funct7 = komut[31:25];

    assign w_imm_i = {{20{komut[31]}}, komut[31:20]};
    assign w_imm_u = {komut[31:12], 12'h000};
    assign w_imm_b = {{19{komut[31]}}, komut[31], komut[7], komut[30:25], komut[11:8], 1'b0};
    assign w_imm_j = {{11{komut[31]}}, komut[31], komut[19:12], komut[20], komut[30:21], 1'b0};

    // Decode opcode/funct fields into control signals and flag undefined encodings
    always_comb begin
        w_alu_op      = ALU_ADD;
        w_wb_sel      = WB_ALU;
        w_use_imm     = 1'b0;
        w_wb_en       = 1'b0;
        w_is_branch   = 1'b0;
        w_is_jal      = 1'b0;
        w_is_jalr     = 1'b0;
        w_dec_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_wb_en  = 1'b1;
                w_wb_sel = WB_LUI;
            end
            OPC_AUIPC: begin
                w_wb_en  = 1'b1;
                w_wb_sel = WB_AUIPC;
            end
            OPC_JAL: begin
                w_wb_en  = 1'b1;
                w_wb_sel = WB_PC4;
                w_is_jal = 1'b1;
            end
            OPC_JALR: begin
                if (w_funct3 != F3_JALR) begin
                    w_dec_illegal = 1'b1;
                end else begin
                    w_wb_en   = 1'b1;
                    w_wb_sel  = WB_PC4;
                    w_is_jalr = 1'b1;
                end
            end
            OPC_BRANCH: begin
                w_is_branch = 1'b1;
                // funct3 010/011 are not branch encodings
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
                    w_dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                w_wb_en   = 1'b1;
                w_use_imm = 1'b1;
                case (w_funct3)
                    F3_ADD:  w_alu_op = ALU_ADD;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_OR:   w_alu_op = ALU_OR;
                    F3_AND:  w_alu_op = ALU_AND;
                    F3_SLL: begin
                        w_alu_op = ALU_SLL;
                        if (w_funct7 != F7_BASE) w_dec_illegal = 1'b1;
                    end
                    default: begin // F3_SR
                        if (w_funct7 == F7_BASE)     w_alu_op = ALU_SRL;
                        else if (w_funct7 == F7_ALT) w_alu_op = ALU_SRA;
                        else                         w_dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                w_wb_en = 1'b1;
                case (w_funct3)
                    F3_ADD: begin
                        if (w_funct7 == F7_BASE)     w_alu_op = ALU_ADD;
                        else if (w_funct7 == F7_ALT) w_alu_op = ALU_SUB;
                        else                         w_dec_illegal = 1'b1;
                    end
                    F3_SR: begin
                        if (w_funct7 == F7_BASE)     w_alu_op = ALU_SRL;
                        else if (w_funct7 == F7_ALT) w_alu_op = ALU_SRA;
                        else                         w_dec_illegal = 1'b1;
                    end
                    default: begin
                        // Remaining ops only exist with the base funct7
                        if (w_funct7 != F7_BASE) w_dec_illegal = 1'b1;
                        case (w_funct3)
                            F3_SLL:  w_alu_op = ALU_SLL;
                            F3_SLT:  w_alu_op = ALU_SLT;
                            F3_SLTU: w_alu_op = ALU_SLTU;
                            F3_XOR:  w_alu_op = ALU_XOR;
                            F3_OR:   w_alu_op = ALU_OR;
                            default: w_alu_op = ALU_AND;
                        endcase
                    end
                endcase
            end
            default: begin
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    genc_regfile regfile (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (w_rf_we),
        .i_wr_addr  (w_rd),
        .i_wr_data  (w_wr_data)
    );

    assign w_alu_b = w_use_imm ? w_imm_i : w_rs2_data;

    // ALU: 32-bit wrap-around arithmetic, shift amount from the low 5 bits of operand b
    always_comb begin
        w_alu_result = 32'd0;
        case (w_alu_op)
            ALU_ADD:  w_alu_result = w_rs1_data + w_alu_b;
            ALU_SUB:  w_alu_result = w_rs1_data - w_alu_b;
            ALU_SLL:  w_alu_result = w_rs1_data << w_alu_b[4:0];
            ALU_SLT:  w_alu_result = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
            ALU_SLTU: w_alu_result = {31'd0, w_rs1_data < w_alu_b};
            ALU_XOR:  w_alu_result = w_rs1_data ^ w_alu_b;
            ALU_SRL:  w_alu_result = w_rs1_data >> w_alu_b[4:0];
            ALU_SRA:  w_alu_result = $unsigned($signed(w_rs1_data) >>> w_alu_b[4:0]);
            ALU_OR:   w_alu_result = w_rs1_data | w_alu_b;
            ALU_AND:  w_alu_result = w_rs1_data & w_alu_b;
            default:  w_alu_result = 32'd0;
        endcase
    end

    // Branch condition evaluation on rs1/rs2
    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            F3_BEQ:  w_br_taken = (w_rs1_data == w_rs2_data);
            F3_BNE:  w_br_taken = (w_rs1_data != w_rs2_data);
            F3_BLT:  w_br_taken = ($signed(w_rs1_data) <  $signed(w_rs2_data));
            F3_BGE:  w_br_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
            F3_BLTU: w_br_taken = (w_rs1_data <  w_rs2_data);
            F3_BGEU: w_br_taken = (w_rs1_data >= w_rs2_data);
            default: w_br_taken = 1'b0;
        endcase
    end

    assign w_pc_plus4 = r_pc + 32'd4;

    // Control-transfer target; JALR clears bit 0 of the computed address
    always_comb begin
        w_target = w_pc_plus4;
        if (w_is_jal) begin
            w_target = r_pc + w_imm_j;
        end else if (w_is_jalr) begin
            w_target = (w_rs1_data + w_imm_i) & 32'hFFFF_FFFE;
        end else if (w_is_branch) begin
            w_target = r_pc + w_imm_b;
        end
    end

    // Writeback data select
    always_comb begin
        w_wr_data = w_alu_result;
        case (w_wb_sel)
            WB_LUI:   w_wr_data = w_imm_u;
            WB_AUIPC: w_wr_data = r_pc + w_imm_u;
            WB_PC4:   w_wr_data = w_pc_plus4;
            default:  w_wr_data = w_alu_result;
        endcase
    end

    assign w_take     = w_is_jal | w_is_jalr | (w_is_branch & w_br_taken & ~w_dec_illegal);
    assign w_misalign = w_take & (w_target[1:0] != 2'b00);
    assign w_fault    = w_dec_illegal | w_misalign;
    assign w_next_pc  = w_take ? w_target : w_pc_plus4;
    assign w_running  = (r_state == ST_RUN);
    // A faulting instruction retires nothing, and a halted core writes nothing
    assign w_rf_we    = w_running & w_wb_en & ~w_fault;

    // pc and run/halt state: advance while running, freeze on the first fault
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_state <= ST_RUN;
        end else if (w_running) begin
            if (w_fault) begin
                r_state <= ST_HALT;
            end else begin
                r_pc <= w_next_pc;
            end
        end
    end

    assign pc   = r_pc;
    assign hata = (r_state == ST_HALT);

endmodule

// File: tb/tb_genc_core.sv
// tb_genc_core: instruction-level reference model of the genc core compared
// against the DUT every cycle, with directed programs pinning known results
// and randomized programs for breadth.
module tb_genc_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] komut;
    logic [31:0] pc;
    logic        hata;

    logic [31:0] imem [64];

    int total = 0;
    int bad   = 0;

    // Reference architectural state
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic        m_hata;
    logic        run_cmp = 1'b0;

    genc_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .komut (komut),
        .pc    (pc),
        .hata  (hata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Word-addressed instruction memory, combinational read
    assign komut = imem[pc[7:2]];

    // ---------------- checking helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc   = 32'd0;
        m_hata = 1'b0;
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Execute one instruction on the model: what the DUT must look like after the next edge
    task automatic model_step();
        logic [31:0] ins, a, b, immi, immu, immb, immj, res, tgt;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wr, ill, take, alt;
        if (m_hata) return;
        ins  = imem[m_pc[7:2]];
        opc  = ins[6:0];
        rd   = ins[11:7];
        f3   = ins[14:12];
        f7   = ins[31:25];
        a    = m_regs[ins[19:15]];
        b    = m_regs[ins[24:20]];
        immi = {{20{ins[31]}}, ins[31:20]};
        immu = {ins[31:12], 12'h000};
        immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        wr = 0; ill = 0; take = 0; res = 0; tgt = 0; alt = 0;
        case (opc)
            7'h37: begin wr = 1; res = immu; end
            7'h17: begin wr = 1; res = m_pc + immu; end
            7'h6F: begin wr = 1; res = m_pc + 4; take = 1; tgt = m_pc + immj; end
            7'h67: begin
                if (f3 != 0) ill = 1;
                else begin wr = 1; res = m_pc + 4; take = 1; tgt = (a + immi) & 32'hFFFF_FFFE; end
            end
            7'h63: begin
                tgt = m_pc + immb;
                case (f3)
                    3'd0: take = (a == b);
                    3'd1: take = (a != b);
                    3'd4: take = ($signed(a) <  $signed(b));
                    3'd5: take = ($signed(a) >= $signed(b));
                    3'd6: take = (a <  b);
                    3'd7: take = (a >= b);
                    default: ill = 1;
                endcase
            end
            7'h13: begin
                wr = 1;
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) alt = 1;
                    else if (f7 != 7'h00) ill = 1;
                end
                res = alu_ref(f3, alt, a, immi);
            end
            7'h33: begin
                wr = 1;
                if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) alt = 1;
                else if (f7 != 7'h00) ill = 1;
                res = alu_ref(f3, alt, a, b);
            end
            default: ill = 1;
        endcase
        if (take && tgt[1:0] != 2'b00) ill = 1;
        if (ill) begin
            m_hata = 1'b1;
        end else begin
            if (wr && rd != 5'd0) m_regs[rd] = res;
            m_pc = take ? tgt : m_pc + 4;
        end
    endtask

    // ---------------- compare process ----------------
    int reg_idx;
    always @(negedge clk) begin
        if (run_cmp) begin
            if (reset) model_reset();
            check32("pc", pc, m_pc);
            check32("hata", {31'd0, hata}, {31'd0, m_hata});
            reg_idx = -1;
            for (int i = 0; i < 32; i++) begin
                if (dut.regfile.regs[i] !== m_regs[i] && reg_idx < 0) reg_idx = i;
            end
            total++;
            if (reg_idx >= 0) begin
                bad++;
                $display("FAIL regs: x%0d got %08h expected %08h (t=%0t)", reg_idx,
                         dut.regfile.regs[reg_idx], m_regs[reg_idx], $time);
            end
            if (!reset) model_step();
        end
    end

    // ---------------- encoders and random program generator ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] rand_instr();
        int          k, off;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [2:0]  br_f3 [6];
        br_f3[0] = 3'd0; br_f3[1] = 3'd1; br_f3[2] = 3'd4;
        br_f3[3] = 3'd5; br_f3[4] = 3'd6; br_f3[5] = 3'd7;
        k   = $urandom_range(0, 99);
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        if (k < 25) begin
            f7 = 7'h00;
            if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
            if ($urandom_range(0, 19) == 0) f7 = 7'($urandom);
            return enc_r(f7, rs2, rs1, f3, rd);
        end else if (k < 50) begin
            if (f3 == 3'd1) imm[11:5] = 7'h00;
            if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            if ((f3 == 3'd1 || f3 == 3'd5) && $urandom_range(0, 19) == 0) imm[11:5] = 7'($urandom);
            return enc_i(imm, rs1, f3, rd, 7'h13);
        end else if (k < 58) begin
            return {20'($urandom), rd, 7'h37};
        end else if (k < 66) begin
            return {20'($urandom), rd, 7'h17};
        end else if (k < 84) begin
            off = $urandom_range(0, 8) * 4 - 12;
            if ($urandom_range(0, 15) == 0) off = 6;
            f3 = br_f3[$urandom_range(0, 5)];
            if ($urandom_range(0, 24) == 0) f3 = 3'd2;
            return enc_b(13'(off), rs2, rs1, f3);
        end else if (k < 90) begin
            off = $urandom_range(0, 6) * 4 - 8;
            if ($urandom_range(0, 9) == 0) off = 2;
            return enc_j(21'(off), rd);
        end else if (k < 94) begin
            if ($urandom_range(0, 1) == 1)
                return enc_i(12'($urandom_range(0, 63) * 4), 5'd0, 3'd0, rd, 7'h67);
            return enc_i(imm, rs1, 3'd0, rd, 7'h67);
        end else if (k < 97) begin
            return $urandom;
        end
        return ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0000_2003;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        fill_nop();
        // Directed program: ALU, branches, jumps, x0 write, illegal word
        imem[0]  = 32'h0050_0093; // addi x1,x0,5
        imem[1]  = 32'h0070_0113; // addi x2,x0,7
        imem[2]  = 32'h4020_81B3; // sub  x3,x1,x2
        imem[3]  = 32'h0000_0463; // beq  x0,x0,+8   -> 0x14
        imem[4]  = 32'hFFFF_FFFF; // skipped
        imem[5]  = 32'h0000_1463; // bne  x0,x0,+8   -> falls through
        imem[6]  = 32'h00C0_00EF; // jal  x1,+12     -> 0x24, x1=0x1C
        imem[7]  = 32'h0010_0013; // addi x0,x0,1
        imem[8]  = 32'hFFFF_FFFF; // illegal
        imem[9]  = 32'h0000_8067; // jalr x0,0(x1)   -> 0x1C

        edges(2);
        check32("rst_pc", pc, 32'h0);
        check32("rst_hata", {31'd0, hata}, 32'h0);
        check32("rst_x5", dut.regfile.regs[5], 32'h0);
        model_reset();
        run_cmp = 1'b1;
        reset   = 1'b0;

        edges(1);
        check32("first_pc", pc, 32'h4);
        check32("first_x1", dut.regfile.regs[1], 32'h5);
        edges(2);
        check32("sub_pc", pc, 32'h0C);
        check32("sub_x2", dut.regfile.regs[2], 32'h7);
        check32("sub_x3", dut.regfile.regs[3], 32'hFFFF_FFFE);
        check32("model_x3", m_regs[3], 32'hFFFF_FFFE);
        edges(1);
        check32("beq_pc", pc, 32'h14);
        edges(1);
        check32("bne_pc", pc, 32'h18);
        edges(1);
        check32("jal_pc", pc, 32'h24);
        check32("jal_x1", dut.regfile.regs[1], 32'h1C);
        edges(1);
        check32("jalr_pc", pc, 32'h1C);
        check32("model_pc", m_pc, 32'h1C);
        edges(1);
        check32("x0_stays", dut.regfile.regs[0], 32'h0);
        check32("x0_pc", pc, 32'h20);
        edges(1);
        check32("ill_hata", {31'd0, hata}, 32'h1);
        check32("ill_pc", pc, 32'h20);
        edges(5);
        check32("halt_pc", pc, 32'h20);
        check32("halt_hata", {31'd0, hata}, 32'h1);
        check32("model_hata", {31'd0, m_hata}, 32'h1);

        // Asynchronous reset out of the halted state
        reset = 1'b1;
        #1;
        check32("rerst_pc", pc, 32'h0);
        check32("rerst_hata", {31'd0, hata}, 32'h0);
        check32("rerst_x1", dut.regfile.regs[1], 32'h0);

        // Fibonacci: 20 iterations of a=b, b=a+b starting from (0,1)
        fill_nop();
        imem[0] = 32'h0000_0093; // addi x1,x0,0
        imem[1] = 32'h0010_0113; // addi x2,x0,1
        imem[2] = 32'h0140_0293; // addi x5,x0,20
        imem[3] = 32'h0020_81B3; // add  x3,x1,x2
        imem[4] = 32'h0001_0093; // addi x1,x2,0
        imem[5] = 32'h0001_8113; // addi x2,x3,0
        imem[6] = 32'hFFF2_8293; // addi x5,x5,-1
        imem[7] = 32'hFE02_98E3; // bne  x5,x0,-16
        imem[8] = 32'h0000_006F; // jal  x0,0 (self-loop)
        edges(2);
        reset = 1'b0;
        edges(130);
        check32("fib_x1", dut.regfile.regs[1], 32'd6765);
        check32("fib_model", m_regs[1], 32'd6765);
        check32("fib_pc", pc, 32'h20);
        check32("fib_x5", dut.regfile.regs[5], 32'h0);
        check32("fib_hata", {31'd0, hata}, 32'h0);

        // Randomized programs, each started from reset
        for (int r = 0; r < 12; r++) begin
            reset = 1'b1;
            for (int i = 0; i < 64; i++) imem[i] = rand_instr();
            edges(2);
            reset = 1'b0;
            edges(60);
        end

        edges(1);
        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
